perceptron_trainer: RTL

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/perceptron_trainer_pkg.sv | 18 +
 rtl/weight_sat_update.sv | 34 +++
 rtl/perceptron_trainer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/perceptron_trainer_pkg.sv
// rtl/perceptron_trainer_pkg.sv - shared types and constants for the perceptron trainer
package perceptron_trainer_pkg;

    localparam int DW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_ZERO = 2'b00;
    localparam err_t ERR_POS  = 2'b01;
    localparam err_t ERR_NEG  = 2'b11;

endpackage

// File: rtl/weight_sat_update.sv
// rtl/weight_sat_update.sv - saturating weight step by +/-(inp >> SHIFT)
module weight_sat_update
    import perceptron_trainer_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [DW-1:0] w_i,
    input  logic [DW-1:0] inp_i,
    input  err_t          err_i,
    input  logic          en_i,
    output logic [DW-1:0] w_o
);

    logic [DW-1:0] step;
    logic [DW:0]   sum;
    logic [DW:0]   diff;

    // One guard bit catches overflow above 15 and borrow below 0.
    assign step = inp_i >> SHIFT;
    assign sum  = {1'b0, w_i} + {1'b0, step};
    assign diff = {1'b0, w_i} - {1'b0, step};

    always_comb begin
        w_o = w_i;
        if (en_i) begin
            if (err_i == ERR_POS) begin
                w_o = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
            end else if (err_i == ERR_NEG) begin
                w_o = diff[DW] ? {DW{1'b0}} : diff[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - perceptron weight trainer; TRAINER_ERRCNT_EN enables err_cnt
module perceptron_trainer
    import perceptron_trainer_pkg::*;
#(
    parameter int            LAT     = 1,
    parameter int            SHIFT   = 1,
    parameter logic [DW-1:0] W1_INIT = 4'd8,
    parameter logic [DW-1:0] W2_INIT = 4'd8,
    parameter logic [DW-1:0] THRESH  = 4'd0
) (
    input  logic          clock,
    input  logic          res,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_inp1,
    input  logic [DW-1:0] s_inp2,
    input  logic          s_target,
    input  logic          freeze,
    output logic [DW-1:0] n_inp1,
    output logic [DW-1:0] n_inp2,
    output logic [DW-1:0] n_w1,
    output logic [DW-1:0] n_w2,
    output logic [DW-1:0] n_t,
    input  logic [DW-1:0] n_out,
    output logic          upd_valid,
    output logic [1:0]    upd_err,
    output logic [7:0]    err_cnt
);

    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] inp1_q, inp2_q;
    logic          target_q;
    logic [DW-1:0] w1_q, w2_q;
    logic [DW-1:0] w1_d, w2_d;
    logic          upd_valid_q;
    err_t          upd_err_q;
    logic          fired;
    logic          upd_en;

    assign fired  = (n_out != '0);
    assign upd_en = (state_q == UPDATE) && !freeze;

    weight_sat_update #(.SHIFT(SHIFT)) u_w1 (
        .w_i   (w1_q),
        .inp_i (inp1_q),
        .err_i (upd_err_q),
        .en_i  (upd_en),
        .w_o   (w1_d)
    );

    weight_sat_update #(.SHIFT(SHIFT)) u_w2 (
        .w_i   (w2_q),
        .inp_i (inp2_q),
        .err_i (upd_err_q),
        .en_i  (upd_en),
        .w_o   (w2_d)
    );

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            inp1_q      <= '0;
            inp2_q      <= '0;
            target_q    <= 1'b0;
            w1_q        <= W1_INIT;
            w2_q        <= W2_INIT;
            upd_valid_q <= 1'b0;
            upd_err_q   <= ERR_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        inp1_q   <= s_inp1;
                        inp2_q   <= s_inp2;
                        target_q <= s_target;
                        cnt_q    <= CW'(LAT);
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    // The last WAIT edge samples the neuron and precomputes the error.
                    if (cnt_q == CW'(1)) begin
                        upd_valid_q <= 1'b1;
                        if (target_q) begin
                            upd_err_q <= fired ? ERR_ZERO : ERR_POS;
                        end else begin
                            upd_err_q <= fired ? ERR_NEG : ERR_ZERO;
                        end
                        state_q <= UPDATE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                UPDATE: begin
                    w1_q        <= w1_d;
                    w2_q        <= w2_d;
                    upd_valid_q <= 1'b0;
                    upd_err_q   <= ERR_ZERO;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TRAINER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Counts regardless of freeze so inference-mode errors are still tallied.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            err_cnt_q <= '0;
        end else if (state_q == UPDATE && upd_err_q != ERR_ZERO && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign s_ready   = (state_q == IDLE);
    assign n_inp1    = inp1_q;
    assign n_inp2    = inp2_q;
    assign n_w1      = w1_q;
    assign n_w2      = w2_q;
    assign n_t       = THRESH;
    assign upd_valid = upd_valid_q;
    assign upd_err   = upd_err_q;

endmodule
